// File: rtl/jtframe_linedbl.sv
// Line doubler: buffers each base-rate line in a ping-pong RAM and
// replays it twice at the doubled pixel rate with a regenerated HSync.
module jtframe_linedbl #(
  parameter int CH  = 3,
  parameter int CW  = 4,
  parameter int AW  = 9,
  parameter int HSW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_cen,
  input  logic             basex2_cen,
  input  logic [CH*CW-1:0] base_pxl,
  input  logic             HS,
  input  logic [1:0]       scan_mode,
  output logic [CH*CW-1:0] x2_pxl,
  output logic             x2_HS,
  output logic [AW:0]      line_len,
  output logic             overflow
);

  localparam int DW = CH*CW;
  localparam logic [AW:0] MAXW = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] HSWL = (AW+1)'(HSW);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [DW-1:0] mem [2**(AW+1)];

  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          bank_q, bank_d;
  logic          odd_q, odd_d;
  logic          hs_l_q, hs_l_d;
  logic          synced_q, synced_d;
  logic [AW:0]   line_len_q, line_len_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] x2_pxl_q, x2_pxl_d;
  logic          x2_hs_q, x2_hs_d;

  logic          hs_edge;
  logic          we;
  logic [AW:0]   waddr;
  logic [AW:0]   raddr;
  logic [DW-1:0] rd_pxl;
  logic          rd_en;

  function automatic logic [DW-1:0] atten(
    input logic [DW-1:0] p,
    input logic [1:0]    m
  );
    logic [DW-1:0] r;
    logic [CW-1:0] c;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      c = p[i*CW +: CW];
      case (m)
        2'b01:   r[i*CW +: CW] = c - (c >> 2);
        2'b10:   r[i*CW +: CW] = c >> 1;
        2'b11:   r[i*CW +: CW] = '0;
        default: r[i*CW +: CW] = c;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    bank_d     = bank_q;
    odd_d      = odd_q;
    hs_l_d     = hs_l_q;
    synced_d   = synced_q;
    line_len_d = line_len_q;
    ovf_d      = ovf_q;
    x2_pxl_d   = x2_pxl_q;
    x2_hs_d    = x2_hs_q;
    we         = 1'b0;
    waddr      = {bank_q, wr_addr_q[AW-1:0]};
    hs_edge    = base_cen & HS & ~hs_l_q;

    if (base_cen) begin
      hs_l_d = HS;
      // The first edge after reset only aligns; the partial line is dropped
      if (hs_edge) begin
        synced_d  = 1'b1;
        if (synced_q) line_len_d = wr_addr_q;
        wr_addr_d = ONE;
        bank_d    = ~bank_q;
        we        = 1'b1;
        waddr     = {~bank_q, {AW{1'b0}}};
      end else if (wr_addr_q < MAXW) begin
        we        = 1'b1;
        wr_addr_d = wr_addr_q + ONE;
      end else if (synced_q) begin
        ovf_d = 1'b1;
      end
    end

    raddr  = {~bank_q, rd_addr_q};
    rd_pxl = mem[raddr];
    rd_en  = basex2_cen & (line_len_q != '0);

    if (rd_en) begin
      x2_pxl_d = atten(rd_pxl, odd_q ? scan_mode : 2'b00);
      x2_hs_d  = {1'b0, rd_addr_q} < HSWL;
      if ({1'b0, rd_addr_q} == line_len_q - ONE) begin
        rd_addr_d = '0;
        odd_d     = ~odd_q;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    if (hs_edge) begin
      rd_addr_d = '0;
      odd_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= base_pxl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      bank_q     <= 1'b0;
      odd_q      <= 1'b0;
      hs_l_q     <= 1'b0;
      synced_q   <= 1'b0;
      line_len_q <= '0;
      ovf_q      <= 1'b0;
      x2_pxl_q   <= '0;
      x2_hs_q    <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      bank_q     <= bank_d;
      odd_q      <= odd_d;
      hs_l_q     <= hs_l_d;
      synced_q   <= synced_d;
      line_len_q <= line_len_d;
      ovf_q      <= ovf_d;
      x2_pxl_q   <= x2_pxl_d;
      x2_hs_q    <= x2_hs_d;
    end
  end

  assign x2_pxl   = x2_pxl_q;
  assign x2_HS    = x2_hs_q;
  assign line_len = line_len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_jtframe_linedbl.sv
// Directed bench for jtframe_linedbl: reset, measurement, replay,
// scanline modes, overflow, resync and mid-line reset.
module tb_jtframe_linedbl;

  logic        clk;
  logic        rst;
  logic        base_cen;
  logic        basex2_cen;
  logic [11:0] base_pxl;
  logic        HS;
  logic [1:0]  scan_mode;
  logic [11:0] x2_pxl;
  logic        x2_HS;
  logic [9:0]  line_len;
  logic        overflow;

  jtframe_linedbl #(
    .CH(3), .CW(4), .AW(9), .HSW(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .base_cen(base_cen),
    .basex2_cen(basex2_cen),
    .base_pxl(base_pxl),
    .HS(HS),
    .scan_mode(scan_mode),
    .x2_pxl(x2_pxl),
    .x2_HS(x2_HS),
    .line_len(line_len),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic [11:0] sp [0:1279];
  logic        sh [0:1279];
  logic [11:0] tail_pxl;
  logic        tail_hs;
  logic        cur_const;
  logic [11:0] cur_cval;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_step(input logic bc, input logic xc);
    base_cen   = bc;
    basex2_cen = xc;
    @(posedge clk);
    #1;
  endtask

  // One input line; base pixel every 4 clk, x2 tick every 2 clk.
  // x2 sample k (k = ticks since the HS edge) lands in sp[k].
  task automatic send_line(input int len, input int cut, input int start);
    for (int i = start; i < len; i++) begin
      if (i == cut) return;
      base_pxl = cur_const ? cur_cval : 12'(i);
      HS = (i < 8);
      clk_step(1'b1, 1'b1);
      if (i == 0) begin
        tail_pxl = x2_pxl;
        tail_hs  = x2_HS;
      end else begin
        sp[2*i-1] = x2_pxl;
        sh[2*i-1] = x2_HS;
      end
      clk_step(1'b0, 1'b0);
      clk_step(1'b0, 1'b1);
      sp[2*i] = x2_pxl;
      sh[2*i] = x2_HS;
      clk_step(1'b0, 1'b0);
    end
  endtask

  task automatic check_replay(input string tag, input int plen,
                              input int nt, input logic pc,
                              input logic [11:0] pcv, input logic useodd,
                              input logic [11:0] oddv);
    int    errs;
    string t2;
    errs = 0;
    t2 = tag;
    for (int t = 0; t < nt; t++) begin
      int          a;
      logic [11:0] e;
      logic        eh;
      a  = (t < plen) ? t : t - plen;
      e  = pc ? pcv : 12'(a);
      if (t >= plen && useodd) e = oddv;
      eh = (a < 32);
      if (sp[t] !== e || sh[t] !== eh) begin
        if (errs == 0)
          t2 = $sformatf("%s t=%0d pxl=%h/%h hs=%b/%b",
                         tag, t, sp[t], e, sh[t], eh);
        errs++;
      end
    end
    chk(t2, 32'(errs), 0);
  endtask

  task automatic idle_check(input string tag, input int lo, input int hi);
    int errs;
    errs = 0;
    for (int t = lo; t <= hi; t++)
      if (sp[t] !== 12'h000 || sh[t] !== 1'b0) errs++;
    chk(tag, 32'(errs), 0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    base_cen   = 1'b0;
    basex2_cen = 1'b0;
    base_pxl   = '0;
    HS         = 1'b0;
    scan_mode  = 2'b00;
    cur_const  = 1'b0;
    cur_cval   = '0;

    for (int i = 0; i < 4; i++) begin
      HS = i[0];
      base_pxl = 12'h5A5;
      clk_step(1'b1, 1'b1);
      chk("reset_outputs", 32'({x2_pxl, x2_HS, line_len, overflow}), 0);
    end
    rst = 1'b0;

    send_line(322, -1, 0);
    idle_check("idle_first_line", 0, 642);
    chk("len_unmeasured", 32'(line_len), 0);

    send_line(322, -1, 0);
    chk("len_322", 32'(line_len), 322);
    check_replay("replay_a", 322, 643, 1'b0, 0, 1'b0, 0);
    send_line(322, -1, 0);
    chk("tail_a", 32'({tail_hs, tail_pxl}), 32'd321);
    check_replay("replay_b", 322, 643, 1'b0, 0, 1'b0, 0);

    cur_const = 1'b1;
    cur_cval  = 12'hF8C;
    scan_mode = 2'b01;
    send_line(322, -1, 0);
    send_line(322, -1, 0);
    check_replay("scan01", 322, 643, 1'b1, 12'hF8C, 1'b1, 12'hC69);
    scan_mode = 2'b10;
    send_line(322, -1, 0);
    chk("mode_switch_tail", 32'({tail_hs, tail_pxl}), 32'h746);
    check_replay("scan10", 322, 643, 1'b1, 12'hF8C, 1'b1, 12'h746);
    scan_mode = 2'b11;
    send_line(322, -1, 0);
    check_replay("scan11", 322, 643, 1'b1, 12'hF8C, 1'b1, 12'h000);
    scan_mode = 2'b00;
    cur_const = 1'b0;

    send_line(600, -1, 0);
    chk("ovf_set", 32'(overflow), 1);
    send_line(300, -1, 0);
    chk("len_sat_512", 32'(line_len), 512);
    check_replay("ovf_replay", 512, 599, 1'b0, 0, 1'b0, 0);
    send_line(300, -1, 0);
    chk("len_300", 32'(line_len), 300);
    chk("ovf_sticky", 32'(overflow), 1);
    check_replay("replay_300", 300, 599, 1'b0, 0, 1'b0, 0);

    send_line(322, -1, 0);
    check_replay("pre_resync", 300, 600, 1'b0, 0, 1'b0, 0);
    send_line(322, -1, 0);
    send_line(300, -1, 0);
    check_replay("resync_trunc", 322, 599, 1'b0, 0, 1'b0, 0);
    send_line(300, -1, 0);
    chk("len_shrunk", 32'(line_len), 300);
    check_replay("resync_300", 300, 599, 1'b0, 0, 1'b0, 0);

    send_line(300, 150, 0);
    chk("tail_300", 32'({tail_hs, tail_pxl}), 32'd299);
    rst = 1'b1;
    HS  = 1'b0;
    clk_step(1'b1, 1'b1);
    chk("midline_rst", 32'({x2_pxl, x2_HS, line_len, overflow}), 0);
    clk_step(1'b0, 1'b0);
    clk_step(1'b0, 1'b1);
    clk_step(1'b0, 1'b0);
    rst = 1'b0;
    send_line(300, -1, 150);
    idle_check("idle_partial", 299, 598);
    send_line(322, -1, 0);
    idle_check("idle_resume", 0, 642);
    chk("len_after_rst", 32'(line_len), 0);
    send_line(322, -1, 0);
    chk("len_resumed", 32'(line_len), 322);
    chk("ovf_cleared", 32'(overflow), 0);
    check_replay("replay_resumed", 322, 643, 1'b0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_linedbl.md
Name: jtframe_linedbl

Overview:
- Parametrised line doubler (scan doubler) for jtframe-based cores.
- Takes base-rate RGB from the game at pxl_cen and re-emits each line twice at pxl2_cen with a regenerated double-rate HSync.
- Sits between the game module and the frame's VGA inputs.
- Successor to the fixed-length 2x doubler, adding:
  - run-time line-length measurement (no HLEN constant)
  - CH×CW channel generalisation
  - selectable scanline attenuation
  - overflow reporting

Parameters:
- CH, 3, number of colour channels packed in the pixel word.
- CW, 4, bits per channel; the pixel word is DW=CH*CW bits, channel 0 in the LSBs.
- AW, 9, line-buffer address width; the maximum line length is MAXW=2**AW pixels.
- HSW, 32, width of x2_HS in basex2_cen ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- base_cen  in  1  input pixel clock enable.
- basex2_cen  in  1  output pixel clock enable; exactly twice the base_cen rate.
- base_pxl  in  CH*CW  input pixel, sampled on base_cen.
- HS  in  1  input horizontal sync, active high.
- scan_mode  in  2  00 off, 01 odd lines 75%, 10 odd lines 50%, 11 odd lines black.
- x2_pxl  out  CH*CW  doubled-rate pixel.
- x2_HS  out  1  doubled-rate horizontal sync.
- line_len  out  AW+1  last measured input line length in pixels.
- overflow  out  1  sticky flag: an input line exceeded MAXW pixels.

Behaviour:
- Reset (synchronous, rst high on a clk edge) clears all state. Outputs then read: x2_pxl=0, x2_HS=0, line_len=0, overflow=0. Internal state cleared: wr_addr=0, rd_addr=0, bank=0, odd=0, HS history=0.
- Reset mid-line discards the partial line; the first full line after reset is measured before any output.
- Buffer: two banks of MAXW×DW (ping-pong). The write side writes bank `bank`; the read side reads bank `~bank`.
- Write side, on each base_cen:
  - Sample HS into hs_l.
  - HS rising edge (HS=1, hs_l=0):
    - line_len <= wr_addr (the pixel count of the line just ended)
    - wr_addr <= 0
    - bank <= ~bank
    - read-side resync: rd_addr <= 0, odd <= 0
    - The current pixel is written at address 0 of the new bank.
  - Otherwise write base_pxl at wr_addr and increment.
  - At wr_addr=MAXW-1: saturate, stop writing further pixels, set overflow. overflow stays set until rst.
  - If the line ends while saturated, line_len=MAXW.
- Read side, on each basex2_cen with line_len≠0:
  - Read bank ~bank at rd_addr; rd_addr increments.
  - When rd_addr=line_len-1: rd_addr <= 0 and odd toggles.
  - This yields two full output lines per input line: odd=0, then odd=1.
  - Resync on the input HS edge has priority over the wrap when both occur on the same clk.
- line_len=0 (no line measured yet): the read side is idle and x2_pxl=0, x2_HS=0.
- Pipeline: memory read is registered. x2_pxl and x2_HS update on the basex2_cen after the address is issued (1-tick latency).
- x2_HS is high while the issued rd_addr<HSW, delayed by the same 1 tick, so it stays aligned with pixel 0. If line_len<=HSW, x2_HS stays high for the whole line.
- Scanline attenuation:
  - Applied per channel on odd=1 lines only; even lines pass unmodified.
  - Mode 01: c - (c>>2), truncating.
  - Mode 10: c>>1.
  - Mode 11: 0.
  - Mode 00: pass-through.
  - No carries between channels; each channel's result stays CW bits.
- scan_mode is sampled per pixel; a change takes effect on the next output pixel.
- A simultaneous base_cen and basex2_cen on the same clk is legal; the write and read sides are independent (dual-port RAM, separate banks).

Test Plan:
- Reset check: hold rst 4 clk with cen active, HS toggling.
  -> All outputs 0 during reset.
  -> No x2 output until one full line has been measured after release.
- Line measurement: 322-pixel lines, base_pxl=pixel index, scan_mode=00.
  -> line_len=322.
  -> Each input line appears twice at x2 with values 0..321, 1-tick latency.
  -> x2_HS high for ticks 0..31 of each output line.
- Scanline modes: CH=3, CW=4, constant pixel 0xF8C.
  -> Even lines 0xF8C.
  -> Odd lines: mode01 0xC69, mode10 0x746, mode11 0x000.
- Overflow: 600-pixel line with AW=9.
  -> overflow=1 and line_len=512; only pixels 0..511 replayed.
  -> overflow remains 1 after a subsequent 300-pixel line (line_len=300).
  -> overflow clears only on rst.
- Resync: shorten a line from 322 to 300 mid-frame.
  -> Read side restarts at rd_addr=0 with odd=0 on the HS edge.
  -> Next lines replay 300 pixels twice with no stale data.
- Mid-line reset: assert rst at input pixel 150.
  -> Outputs 0 immediately.
  -> Normal doubling resumes after the second HS rising edge following release.
